// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the master-interface FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_SPLIT_WAIT,
    ST_RESP
  } state_t;

  localparam int TIMEOUT_W = 5;

endpackage

// File: rtl/ahb_master_if.sv
// Single-transfer AHB master: turns one local command into one NONSEQ transfer,
// with split/reissue handling, data-phase timeout and a one-cycle response pulse.
module ahb_master_if
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        hbusreq,
  input  logic        hgrant,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata,
  input  logic        split_in,
  input  logic        valid_aft_split_in
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]        RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [TIMEOUT_W-1:0] TO_LIMIT    = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_W-1:0] TO_MAX      = '1;

  state_t                 state_q, state_d;
  logic                   write_q, write_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [TIMEOUT_W-1:0]   to_q, to_d;
  logic [TIMEOUT_W-1:0]   to_inc;
  logic                   live_q;

  // live_q keeps cmd_ready low until the first clock edge after reset release.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      retry_q <= '0;
      to_q    <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      to_q    <= to_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    retry_d = retry_q;
    to_d    = to_q;
    to_inc  = (to_q == TO_MAX) ? to_q : to_q + TIMEOUT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && live_q) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          err_d   = 1'b0;
          retry_d = '0;
          to_d    = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (hgrant) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (hready) state_d = ST_DATA;
      end
      ST_DATA: begin
        // Error response outranks split, which outranks normal completion.
        if (hresp == HRESP_ERROR) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (split_in) begin
          if (retry_q == RETRY_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = ST_SPLIT_WAIT;
          end
        end else if (hready) begin
          err_d = 1'b0;
          if (!write_q) rdata_d = hrdata;
          state_d = ST_RESP;
        end else begin
          to_d = to_inc;
          if (to_inc == TO_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_SPLIT_WAIT: begin
        if (valid_aft_split_in) begin
          to_d    = '0;
          state_d = ST_REQ;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE) && live_q;
  assign hbusreq   = (state_q == ST_REQ) || (state_q == ST_ADDR);
  assign htrans    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr     = addr_q;
  assign hwrite    = write_q;
  assign hwdata    = wdata_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_error = (state_q == ST_RESP) && err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ahb_master_if.sv
// Scenario bench for ahb_master_if: scoreboard of expected responses checked on rsp_valid.
module tb_ahb_master_if;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        hbusreq, hgrant;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic        hwrite, hready, hresp, split_in, valid_aft_split_in;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          nonseq_cnt = 0;
  int          rsp_cnt = 0;
  logic [31:0] exp_rdata;

  ahb_master_if #(.TIMEOUT_CYCLES(16), .MAX_RETRY(3)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hresp(hresp),
    .hrdata(hrdata), .split_in(split_in), .valid_aft_split_in(valid_aft_split_in)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  always @(negedge hclk) begin
    if (htrans == 2'b10) nonseq_cnt++;
    if (rsp_valid) begin
      rsp_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no command pending, required 0");
      end else begin
        m = sb.pop_front();
        if (rsp_error !== m.err) begin
          errors++;
          $display("FAIL rsp_error: got %0b required %0b", rsp_error, m.err);
        end
        checks++;
        if (rsp_rdata !== m.rdata) begin
          errors++;
          $display("FAIL rsp_rdata: got %08h required %08h", rsp_rdata, m.rdata);
        end
        if (m.lat > 0) begin
          checks++;
          if (cyc - m.t_acc != m.lat) begin
            errors++;
            $display("FAIL rsp_latency: got %0d required %0d", cyc - m.t_acc, m.lat);
          end
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit e_err, input logic [31:0] e_rd, input int lat);
    exp_t x;
    int   n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge hclk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    x.err = e_err; x.rdata = e_rd; x.lat = lat; x.t_acc = cyc;
    sb.push_back(x);
    @(negedge hclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_nonseq(input int budget, output bit ok);
    ok = (htrans == 2'b10);
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge hclk);
      ok = (htrans == 2'b10);
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = rsp_valid;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge hclk);
      ok = rsp_valid;
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    hgrant = 1; hready = 1; hresp = 0; hrdata = 0; split_in = 0; valid_aft_split_in = 0;
    exp_rdata = 32'h0;
    repeat (2) @(negedge hclk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_error, hbusreq, hwrite} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: {ready,valid,err,busreq,hwrite}=%05b required 00000",
               {cmd_ready, rsp_valid, rsp_error, hbusreq, hwrite});
    end
    checks++;
    if (htrans !== 2'b00) begin
      errors++; $display("FAIL reset_htrans: got %02b required 00", htrans);
    end
    checks++;
    if ({haddr, hwdata, rsp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: haddr=%08h hwdata=%08h rdata=%08h required 0", haddr, hwdata, rsp_rdata);
    end
    hresetn = 1'b1;
    @(negedge hclk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %0b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    bit ok;
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, exp_rdata, 4);
    checks++;
    if (hbusreq !== 1'b1 || htrans !== 2'b00 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_req_phase: busreq=%0b htrans=%02b ready=%0b required 1 00 0", hbusreq, htrans, cmd_ready);
    end
    @(negedge hclk);
    checks++;
    if (htrans !== 2'b10 || haddr !== 32'h10 || hwrite !== 1'b1) begin
      errors++;
      $display("FAIL wr_addr_phase: htrans=%02b haddr=%08h hwrite=%0b required 10 00000010 1", htrans, haddr, hwrite);
    end
    @(negedge hclk);
    checks++;
    if (hwdata !== 32'hDEAD_BEEF || htrans !== 2'b00 || hbusreq !== 1'b0) begin
      errors++;
      $display("FAIL wr_data_phase: hwdata=%08h htrans=%02b busreq=%0b required deadbeef 00 0", hwdata, htrans, hbusreq);
    end
    wait_rsp(4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_rsp_wait: rsp_valid=0 required 1"); end
    @(negedge hclk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_rsp_pulse: valid=%0b ready=%0b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_wait();
    bit ok;
    exp_rdata = 32'h0000_0005;
    issue(1'b0, 32'h0000_0004, 32'h0, 1'b0, exp_rdata, 7);
    wait_nonseq(4, ok);
    checks++;
    if (!ok || haddr !== 32'h4 || hwrite !== 1'b0) begin
      errors++; $display("FAIL rd_addr_phase: ok=%0b haddr=%08h hwrite=%0b required 1 00000004 0", ok, haddr, hwrite);
    end
    @(negedge hclk);
    hready = 1'b0;
    repeat (3) @(negedge hclk);
    hready = 1'b1; hrdata = 32'h0000_0005;
    wait_rsp(4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_rsp_wait: rsp_valid=0 required 1"); end
    @(negedge hclk);
  endtask

  task automatic test_split();
    bit ok;
    int n0;
    n0 = nonseq_cnt;
    hrdata = 32'hA5A5_0001;
    exp_rdata = 32'hA5A5_0001;
    issue(1'b0, 32'h0000_0020, 32'h0, 1'b0, exp_rdata, 0);
    wait_nonseq(4, ok);
    @(negedge hclk);
    split_in = 1'b1;
    for (int i = 1; i < 7; i++) begin
      @(negedge hclk);
      if (i == 2) begin
        checks++;
        if (htrans !== 2'b00 || hbusreq !== 1'b0 || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL split_wait_state: htrans=%02b busreq=%0b valid=%0b required 00 0 0", htrans, hbusreq, rsp_valid);
        end
      end
    end
    @(negedge hclk);
    split_in = 1'b0; valid_aft_split_in = 1'b1;
    @(negedge hclk);
    valid_aft_split_in = 1'b0;
    wait_nonseq(6, ok);
    checks++;
    if (!ok || haddr !== 32'h20) begin
      errors++; $display("FAIL split_reissue: ok=%0b haddr=%08h required 1 00000020", ok, haddr);
    end
    wait_rsp(6, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL split_rsp_wait: rsp_valid=0 required 1"); end
    @(negedge hclk);
    checks++;
    if (nonseq_cnt - n0 != 2) begin
      errors++; $display("FAIL split_nonseq_count: got %0d required 2", nonseq_cnt - n0);
    end
  endtask

  task automatic test_retry_exhaust();
    bit ok;
    int n0;
    n0 = nonseq_cnt;
    issue(1'b0, 32'h0000_0030, 32'h0, 1'b1, exp_rdata, 0);
    for (int k = 0; k < 4; k++) begin
      wait_nonseq(6, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL retry_nonseq_%0d: not seen, required NONSEQ", k); end
      @(negedge hclk);
      split_in = 1'b1;
      @(negedge hclk);
      split_in = 1'b0;
      if (k < 3) begin
        valid_aft_split_in = 1'b1;
        @(negedge hclk);
        valid_aft_split_in = 1'b0;
      end
    end
    wait_rsp(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL retry_rsp_wait: rsp_valid=0 required 1"); end
    repeat (6) @(negedge hclk);
    checks++;
    if (nonseq_cnt - n0 != 4) begin
      errors++; $display("FAIL retry_nonseq_count: got %0d required 4", nonseq_cnt - n0);
    end
  endtask

  task automatic test_hresp_error();
    bit ok;
    issue(1'b1, 32'h0000_0040, 32'h1111_2222, 1'b1, exp_rdata, 4);
    wait_nonseq(4, ok);
    @(negedge hclk);
    hresp = 1'b1; hready = 1'b0; split_in = 1'b1;
    @(negedge hclk);
    hresp = 1'b0; hready = 1'b1; split_in = 1'b0;
    wait_rsp(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hresp_rsp_wait: rsp_valid=0 required 1"); end
    @(negedge hclk);
  endtask

  task automatic test_timeout();
    bit ok;
    hrdata = 32'hBAD0_BAD0;
    issue(1'b0, 32'h0000_0050, 32'h0, 1'b1, exp_rdata, 19);
    wait_nonseq(4, ok);
    @(negedge hclk);
    hready = 1'b0;
    wait_rsp(40, ok);
    hready = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_rsp_wait: rsp_valid=0 required 1"); end
    @(negedge hclk);
  endtask

  task automatic test_grant_delay();
    bit ok;
    hgrant = 1'b0;
    issue(1'b1, 32'h0000_0060, 32'h1234_5678, 1'b0, exp_rdata, 6);
    cmd_valid = 1'b1; cmd_addr = 32'hFFFF_FFF0; cmd_write = 1'b0;
    @(negedge hclk);
    checks++;
    if (hbusreq !== 1'b1 || htrans !== 2'b00 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL grant_wait: busreq=%0b htrans=%02b ready=%0b required 1 00 0", hbusreq, htrans, cmd_ready);
    end
    cmd_valid = 1'b0;
    @(negedge hclk);
    hgrant = 1'b1;
    wait_nonseq(4, ok);
    checks++;
    if (!ok || haddr !== 32'h60 || hwrite !== 1'b1) begin
      errors++; $display("FAIL grant_addr: ok=%0b haddr=%08h hwrite=%0b required 1 00000060 1", ok, haddr, hwrite);
    end
    wait_rsp(4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL grant_rsp_wait: rsp_valid=0 required 1"); end
    @(negedge hclk);
  endtask

  task automatic test_back_to_back();
    bit          ok;
    logic [31:0] a, d;
    for (int i = 0; i < 6; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom;
      if (i % 2 == 1) begin
        hrdata = d;
        exp_rdata = d;
      end
      issue(i % 2 == 0, a, d, 1'b0, exp_rdata, 4);
      wait_rsp(6, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_rsp_wait_%0d: rsp_valid=0 required 1", i); end
    end
    @(negedge hclk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rc;
    issue(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 1'b0, exp_rdata, 4);
    wait_nonseq(4, ok);
    @(negedge hclk);
    hready = 1'b0;
    #2 hresetn = 1'b0;
    #1;
    checks++;
    if (htrans !== 2'b00 || hbusreq !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: htrans=%02b busreq=%0b ready=%0b valid=%0b required 00 0 0 0",
               htrans, hbusreq, cmd_ready, rsp_valid);
    end
    checks++;
    if (haddr !== 32'h0 || hwdata !== 32'h0 || hwrite !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_data: haddr=%08h hwdata=%08h hwrite=%0b rdata=%08h required 0",
               haddr, hwdata, hwrite, rsp_rdata);
    end
    sb.delete();
    exp_rdata = 32'h0;
    rc = rsp_cnt;
    repeat (3) @(negedge hclk);
    hresetn = 1'b1; hready = 1'b1;
    @(negedge hclk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready: got %0b required 1", cmd_ready);
    end
    checks++;
    if (rsp_cnt != rc) begin
      errors++; $display("FAIL midrst_no_rsp: got %0d pulses required 0", rsp_cnt - rc);
    end
    hrdata = 32'h600D_F00D;
    exp_rdata = 32'h600D_F00D;
    issue(1'b0, 32'h0000_0084, 32'h0, 1'b0, exp_rdata, 4);
    wait_rsp(6, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_after_rsp: rsp_valid=0 required 1"); end
    repeat (2) @(negedge hclk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_split();
    test_retry_exhaust();
    test_hresp_error();
    test_timeout();
    test_grant_delay();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d responses outstanding required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
